// File: rtl/bank_ctrl_pkg.sv
// Shared definitions for the CAM/MAC bank sequencer: op encodings, FSM states
// and the counter width helper.
package bank_ctrl_pkg;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_READ_Q  = 2'b01;
  localparam logic [1:0] OP_READ_QB = 2'b10;
  localparam logic [1:0] OP_SEARCH  = 2'b11;

  typedef enum logic [2:0] {
    StSleep,
    StWake,
    StIdle,
    StMode,
    StOp,
    StResp
  } state_e;

  // Width able to hold the largest phase length or idle timeout.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 2) ? 32'd1 : 32'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/bank_prio_enc.sv
// Lowest-index priority encoder for a 4-row match vector.
module bank_prio_enc (
  input  logic [3:0] match_i,
  output logic       hit_o,
  output logic [1:0] idx_o
);

  always_comb begin
    hit_o = |match_i;
    idx_o = 2'd0;
    if (match_i[0]) begin
      idx_o = 2'd0;
    end else if (match_i[1]) begin
      idx_o = 2'd1;
    end else if (match_i[2]) begin
      idx_o = 2'd2;
    end else if (match_i[3]) begin
      idx_o = 2'd3;
    end
  end

endmodule

// File: rtl/bank_ctrl.sv
// Single-bank CAM/MAC sequencer: accepts one command, settles the mode pin, times the
// access phase, captures the result and returns one response; sleeps after idling.
module bank_ctrl
  import bank_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WR_CYCLES     = 1,
  parameter int unsigned RD_CYCLES     = 2,
  parameter int unsigned SRCH_CYCLES   = 2,
  parameter int unsigned IDLE_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [3:0] cmd_query,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_hit,
  output logic [1:0] rsp_hit_idx,
  output logic       sleeping,
  output logic       CS,
  output logic       MAC_en,
  output logic       w_en,
  output logic       read_bar,
  output logic [1:0] addr,
  output logic [7:0] word,
  output logic [3:0] query,
  input  logic [7:0] bank_rdata,
  input  logic [3:0] bank_match
);

  localparam int unsigned CntW =
      cnt_width(SETTLE_CYCLES, WR_CYCLES, RD_CYCLES, SRCH_CYCLES, IDLE_TIMEOUT);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] IdleLast = CntW'(IDLE_TIMEOUT - 1);

  state_e          state_q;
  logic [1:0]      op_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] idle_cnt_q;
  logic            cmd_ready_q, rsp_valid_q, rsp_hit_q, sleeping_q;
  logic [7:0]      rsp_data_q, word_q;
  logic [1:0]      rsp_hit_idx_q, addr_q;
  logic            cs_q, mac_en_q, w_en_q, read_bar_q;
  logic [3:0]      query_q;

  logic            hit;
  logic [1:0]      hit_idx;
  logic [1:0]      chk_op;
  logic            mode_ok;

  function automatic logic [CntW-1:0] op_load(input logic [1:0] op);
    case (op)
      OP_WRITE:  return CntW'(WR_CYCLES - 1);
      OP_SEARCH: return CntW'(SRCH_CYCLES - 1);
      default:   return CntW'(RD_CYCLES - 1);
    endcase
  endfunction

  bank_prio_enc u_prio_enc (
    .match_i (bank_match),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

  // From WAKE the mode check uses the latched op; from IDLE it uses the incoming one.
  assign chk_op  = (state_q == StWake) ? op_q : cmd_op;
  assign mode_ok = (mac_en_q == (chk_op != OP_SEARCH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StSleep;
      op_q          <= OP_WRITE;
      cnt_q         <= '0;
      idle_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_hit_q     <= 1'b0;
      rsp_hit_idx_q <= 2'd0;
      sleeping_q    <= 1'b1;
      cs_q          <= 1'b0;
      mac_en_q      <= 1'b1;
      w_en_q        <= 1'b0;
      read_bar_q    <= 1'b1;
      addr_q        <= 2'd0;
      word_q        <= 8'h00;
      query_q       <= 4'h0;
    end else begin
      unique case (state_q)
        StSleep: begin
          idle_cnt_q <= '0;
          if (cmd_valid) begin
            op_q        <= cmd_op;
            addr_q      <= cmd_addr;
            read_bar_q  <= (cmd_op != OP_READ_Q);
            if (cmd_op == OP_WRITE) word_q <= cmd_wdata;
            if (cmd_op == OP_SEARCH) query_q <= cmd_query;
            cs_q        <= 1'b1;
            sleeping_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            state_q     <= StWake;
          end
        end
        StWake: begin
          if (!mode_ok) begin
            mac_en_q <= ~mac_en_q;
            cnt_q    <= SettleLd;
            state_q  <= StMode;
          end else begin
            cnt_q   <= op_load(chk_op);
            w_en_q  <= (chk_op == OP_WRITE);
            state_q <= StOp;
          end
        end
        StIdle: begin
          if (cmd_valid) begin
            idle_cnt_q  <= '0;
            op_q        <= cmd_op;
            addr_q      <= cmd_addr;
            read_bar_q  <= (cmd_op != OP_READ_Q);
            if (cmd_op == OP_WRITE) word_q <= cmd_wdata;
            if (cmd_op == OP_SEARCH) query_q <= cmd_query;
            cmd_ready_q <= 1'b0;
            if (!mode_ok) begin
              mac_en_q <= ~mac_en_q;
              cnt_q    <= SettleLd;
              state_q  <= StMode;
            end else begin
              cnt_q   <= op_load(chk_op);
              w_en_q  <= (chk_op == OP_WRITE);
              state_q <= StOp;
            end
          end else if ((IDLE_TIMEOUT != 0) && (idle_cnt_q == IdleLast)) begin
            idle_cnt_q <= '0;
            cs_q       <= 1'b0;
            sleeping_q <= 1'b1;
            state_q    <= StSleep;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        StMode: begin
          if (cnt_q == '0) begin
            cnt_q   <= op_load(op_q);
            w_en_q  <= (op_q == OP_WRITE);
            state_q <= StOp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StOp: begin
          if (cnt_q == '0) begin
            w_en_q      <= 1'b0;
            read_bar_q  <= 1'b1;
            rsp_valid_q <= 1'b1;
            if ((op_q == OP_READ_Q) || (op_q == OP_READ_QB)) rsp_data_q <= bank_rdata;
            if (op_q == OP_SEARCH) begin
              rsp_hit_q     <= hit;
              rsp_hit_idx_q <= hit_idx;
            end
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_hit_q     <= 1'b0;
            rsp_hit_idx_q <= 2'd0;
            idle_cnt_q    <= '0;
            cmd_ready_q   <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StSleep;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_hit     = rsp_hit_q;
  assign rsp_hit_idx = rsp_hit_idx_q;
  assign sleeping    = sleeping_q;
  assign CS          = cs_q;
  assign MAC_en      = mac_en_q;
  assign w_en        = w_en_q;
  assign read_bar    = read_bar_q;
  assign addr        = addr_q;
  assign word        = word_q;
  assign query       = query_q;

endmodule

// File: tb/tb_bank_ctrl.sv
// Directed bench for bank_ctrl with default timing parameters.
module tb_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op, cmd_addr;
  logic [7:0] cmd_wdata;
  logic [3:0] cmd_query;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_hit;
  logic [1:0] rsp_hit_idx;
  logic       sleeping, CS, MAC_en, w_en, read_bar;
  logic [1:0] addr;
  logic [7:0] word;
  logic [3:0] query;
  logic [7:0] bank_rdata;
  logic [3:0] bank_match;

  int vectors     = 0;
  int miscompares = 0;
  int rsp_seen    = 0;
  int wen_cycles  = 0;

  always #5 clk = ~clk;

  bank_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_query   (cmd_query),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_hit     (rsp_hit),
    .rsp_hit_idx (rsp_hit_idx),
    .sleeping    (sleeping),
    .CS          (CS),
    .MAC_en      (MAC_en),
    .w_en        (w_en),
    .read_bar    (read_bar),
    .addr        (addr),
    .word        (word),
    .query       (query),
    .bank_rdata  (bank_rdata),
    .bank_match  (bank_match)
  );

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) rsp_seen++;
    if (w_en) wen_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns just after its accept edge.
  task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [7:0] wd,
                      input logic [3:0] q);
    int n;
    n = 0;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_query = q;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 64) begin
      tick();
      n++;
    end
    check_eq("send_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_cs"}, {31'd0, CS}, 32'd0);
    check_eq({tag, "_mac"}, {31'd0, MAC_en}, 32'd1);
    check_eq({tag, "_wen"}, {31'd0, w_en}, 32'd0);
    check_eq({tag, "_rb"}, {31'd0, read_bar}, 32'd1);
    check_eq({tag, "_addr"}, {30'd0, addr}, 32'd0);
    check_eq({tag, "_word"}, {24'd0, word}, 32'd0);
    check_eq({tag, "_query"}, {28'd0, query}, 32'd0);
    check_eq({tag, "_rspv"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_rspd"}, {24'd0, rsp_data}, 32'd0);
    check_eq({tag, "_hit"}, {31'd0, rsp_hit}, 32'd0);
    check_eq({tag, "_idx"}, {30'd0, rsp_hit_idx}, 32'd0);
    check_eq({tag, "_sleep"}, {31'd0, sleeping}, 32'd1);
    check_eq({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 2'd0; cmd_wdata = 8'h00;
    cmd_query = 4'h0; rsp_ready = 1'b1; bank_rdata = 8'h00; bank_match = 4'h0;
    #1;
    check_reset("por");
    tick(); tick();
    rst = 1'b0;
    tick();

    // WRITE from SLEEP: one WAKE cycle then a single w_en cycle.
    send(2'd0, 2'd0, 8'hAA, 4'h0);
    check_eq("w1_cs", {31'd0, CS}, 32'd1);
    check_eq("w1_sleep", {31'd0, sleeping}, 32'd0);
    check_eq("w1_rdy", {31'd0, cmd_ready}, 32'd0);
    check_eq("w1_wake_wen", {31'd0, w_en}, 32'd0);
    tick();
    check_eq("w1_wen", {31'd0, w_en}, 32'd1);
    check_eq("w1_addr", {30'd0, addr}, 32'd0);
    check_eq("w1_word", {24'd0, word}, 32'hAA);
    check_eq("w1_mac", {31'd0, MAC_en}, 32'd1);
    check_eq("w1_rspv0", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("w1_wen_off", {31'd0, w_en}, 32'd0);
    check_eq("w1_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("w1_rspd", {24'd0, rsp_data}, 32'd0);
    tick();
    check_eq("w1_rsp_done", {31'd0, rsp_valid}, 32'd0);
    check_eq("w1_rdy_back", {31'd0, cmd_ready}, 32'd1);

    // READ_Q then READ_QB.
    bank_rdata = 8'h55;
    send(2'd1, 2'd1, 8'h00, 4'h0);
    check_eq("rq_rb", {31'd0, read_bar}, 32'd0);
    check_eq("rq_addr", {30'd0, addr}, 32'd1);
    tick();
    check_eq("rq_rb2", {31'd0, read_bar}, 32'd0);
    check_eq("rq_rspv0", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("rq_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("rq_data", {24'd0, rsp_data}, 32'h55);
    check_eq("rq_rb_rel", {31'd0, read_bar}, 32'd1);
    tick();
    bank_rdata = 8'h3C;
    send(2'd2, 2'd2, 8'h00, 4'h0);
    check_eq("rqb_rb", {31'd0, read_bar}, 32'd1);
    check_eq("rqb_addr", {30'd0, addr}, 32'd2);
    tick(); tick();
    check_eq("rqb_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("rqb_data", {24'd0, rsp_data}, 32'h3C);
    tick();

    // SEARCH after reads: one settle cycle, then two query cycles.
    bank_match = 4'b0110;
    send(2'd3, 2'd0, 8'h00, 4'hA);
    check_eq("s1_mac", {31'd0, MAC_en}, 32'd0);
    check_eq("s1_query", {28'd0, query}, 32'hA);
    check_eq("s1_word_kept", {24'd0, word}, 32'hAA);
    tick();
    check_eq("s1_rspv_a", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("s1_rspv_b", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("s1_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("s1_hit", {31'd0, rsp_hit}, 32'd1);
    check_eq("s1_idx", {30'd0, rsp_hit_idx}, 32'd1);
    check_eq("s1_data", {24'd0, rsp_data}, 32'd0);
    tick();
    bank_match = 4'b0000;
    send(2'd3, 2'd0, 8'h00, 4'hF);
    check_eq("s2_mac", {31'd0, MAC_en}, 32'd0);
    tick();
    check_eq("s2_rspv0", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("s2_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("s2_hit", {31'd0, rsp_hit}, 32'd0);
    check_eq("s2_idx", {30'd0, rsp_hit_idx}, 32'd0);
    tick();
    bank_match = 4'b1000;
    send(2'd3, 2'd0, 8'h00, 4'h3);
    tick(); tick();
    check_eq("s3_hit", {31'd0, rsp_hit}, 32'd1);
    check_eq("s3_idx", {30'd0, rsp_hit_idx}, 32'd3);
    tick();

    // WRITE after SEARCH reinserts the settle cycle.
    send(2'd0, 2'd3, 8'h5A, 4'h0);
    check_eq("w2_mac", {31'd0, MAC_en}, 32'd1);
    check_eq("w2_mode_wen", {31'd0, w_en}, 32'd0);
    tick();
    check_eq("w2_wen", {31'd0, w_en}, 32'd1);
    check_eq("w2_word", {24'd0, word}, 32'h5A);
    check_eq("w2_addr", {30'd0, addr}, 32'd3);
    tick();
    check_eq("w2_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("w2_wen_off", {31'd0, w_en}, 32'd0);
    tick();

    // Response backpressure with a pending command.
    rsp_ready  = 1'b0;
    bank_rdata = 8'hA5;
    send(2'd1, 2'd1, 8'h00, 4'h0);
    tick(); tick();
    check_eq("bp_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp_data", {24'd0, rsp_data}, 32'hA5);
    bank_rdata = 8'h00;
    cmd_op = 2'd2; cmd_addr = 2'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hold_v", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp_hold_d", {24'd0, rsp_data}, 32'hA5);
      check_eq("bp_hold_rdy", {31'd0, cmd_ready}, 32'd0);
      check_eq("bp_hold_addr", {30'd0, addr}, 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_rel_v", {31'd0, rsp_valid}, 32'd0);
    check_eq("bp_rel_d", {24'd0, rsp_data}, 32'd0);
    check_eq("bp_rel_rdy", {31'd0, cmd_ready}, 32'd1);
    check_eq("bp_rel_addr", {30'd0, addr}, 32'd1);
    bank_rdata = 8'h81;
    tick();
    check_eq("bp_acc_rdy", {31'd0, cmd_ready}, 32'd0);
    check_eq("bp_acc_rb", {31'd0, read_bar}, 32'd1);
    check_eq("bp_acc_addr", {30'd0, addr}, 32'd0);
    cmd_valid = 1'b0;
    tick(); tick();
    check_eq("bp_q_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp_q_data", {24'd0, rsp_data}, 32'h81);
    tick();

    // Idle timeout: sleep on the 16th idle cycle, state retained.
    for (int i = 0; i < 15; i++) tick();
    check_eq("to_cs15", {31'd0, CS}, 32'd1);
    check_eq("to_sleep15", {31'd0, sleeping}, 32'd0);
    tick();
    check_eq("to_cs16", {31'd0, CS}, 32'd0);
    check_eq("to_sleep16", {31'd0, sleeping}, 32'd1);
    check_eq("to_rdy", {31'd0, cmd_ready}, 32'd1);
    check_eq("to_mac", {31'd0, MAC_en}, 32'd1);
    check_eq("to_word", {24'd0, word}, 32'h5A);
    check_eq("to_query", {28'd0, query}, 32'h3);

    // Command from SLEEP costs one extra WAKE cycle.
    bank_rdata = 8'h77;
    send(2'd1, 2'd1, 8'h00, 4'h0);
    check_eq("wk_cs", {31'd0, CS}, 32'd1);
    check_eq("wk_sleep", {31'd0, sleeping}, 32'd0);
    tick();
    check_eq("wk_rspv_a", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("wk_rspv_b", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("wk_rspv", {31'd0, rsp_valid}, 32'd1);
    check_eq("wk_data", {24'd0, rsp_data}, 32'h77);
    tick();

    // cmd_valid exactly on the timeout cycle wins.
    for (int i = 0; i < 15; i++) tick();
    cmd_op = 2'd0; cmd_addr = 2'd2; cmd_wdata = 8'h33; cmd_valid = 1'b1;
    tick();
    check_eq("tw_cs", {31'd0, CS}, 32'd1);
    check_eq("tw_sleep", {31'd0, sleeping}, 32'd0);
    check_eq("tw_wen", {31'd0, w_en}, 32'd1);
    check_eq("tw_word", {24'd0, word}, 32'h33);
    cmd_valid = 1'b0;
    tick();
    check_eq("tw_rspv", {31'd0, rsp_valid}, 32'd1);
    tick();

    // Reset in the middle of a two-cycle read.
    bank_rdata = 8'h99;
    send(2'd1, 2'd2, 8'h00, 4'h0);
    tick();
    rst = 1'b1;
    #1;
    check_reset("mid");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    check_eq("rsp_count", rsp_seen, 32'd11);
    check_eq("wen_count", wen_cycles, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bank_ctrl.md
Name: bank_ctrl

Overview:
- Sequencer that sits in front of one CAM/MAC memory bank and drives its pins: CS, MAC_en, w_en, read_bar, addr, word, query.
- Accepts one command at a time over a valid/ready interface, inserts mode-switch settle time and chip wake-up, and times write/read/search phases.
- Captures the bank result and returns exactly one response per command.
- Deselects the bank after an idle timeout.

Parameters:
- SETTLE_CYCLES, 1, cycles MAC_en is held at its new value before any operation after a mode change (>=1).
- WR_CYCLES, 1, width of the w_en pulse in cycles (>=1).
- RD_CYCLES, 2, cycles addr/read_bar are held before bank_rdata is sampled (>=1).
- SRCH_CYCLES, 2, cycles query is held before bank_match is sampled (>=1).
- IDLE_TIMEOUT, 16, consecutive idle cycles before CS drops; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_op  in  2  00 WRITE, 01 READ_Q, 10 READ_QB, 11 SEARCH.
- cmd_addr  in  2  row address.
- cmd_wdata  in  8  write word.
- cmd_query  in  4  CAM search key.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  8  read data; 0 for WRITE and SEARCH.
- rsp_hit  out  1  SEARCH: any match line set; 0 otherwise.
- rsp_hit_idx  out  2  SEARCH: lowest-index matching row; 0 if no hit.
- sleeping  out  1  high while CS=0.
- CS, MAC_en, w_en, read_bar  out  1 each  bank control pins.
- addr  out  2  bank row address.
- word  out  8  bank write data.
- query  out  4  bank search key.
- bank_rdata  in  8  bank read data (Q or QB per read_bar).
- bank_match  in  4  bank match lines, bit i = row i.

Behaviour:
- All outputs registered.
- Reset values: CS=0, MAC_en=1, w_en=0, read_bar=1, addr=0, word=0, query=0, rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_hit_idx=0, sleeping=1, state SLEEP. cmd_ready=1.
- States:
  - SLEEP: CS=0, cmd_ready=1.
  - WAKE: 1 cycle, CS=1.
  - IDLE: cmd_ready=1.
  - MODE: MAC_en switched; lasts SETTLE_CYCLES.
  - OP: lasts WR/RD/SRCH_CYCLES.
  - RESP: rsp_valid=1.
- cmd_ready=1 only in SLEEP and IDLE.
- Accept edge:
  - Latch op.
  - Drive addr<=cmd_addr, word<=cmd_wdata (WRITE only), query<=cmd_query (SEARCH only).
  - read_bar<=0 for READ_Q, 1 for READ_QB.
  - From SLEEP: CS<=1, next state WAKE. Otherwise go to the mode check.
- Mode check: WRITE/READ need MAC_en=1, SEARCH needs MAC_en=0.
  - Mismatch: toggle MAC_en, enter MODE.
  - Match: enter OP directly.
- OP: w_en=1 for all WR_CYCLES cycles of a WRITE, 0 otherwise.
- OP exit edge:
  - w_en<=0, read_bar<=1, rsp_valid<=1.
  - READ: rsp_data<=bank_rdata.
  - SEARCH: rsp_hit<=|bank_match, rsp_hit_idx<=lowest set bit.
- Latency from an IDLE accept edge t0 with no mode switch: rsp_valid rises at edge t0+N, where N is the op's cycle count. Add SETTLE_CYCLES for a mode switch; add 1 from SLEEP.
- RESP: all result outputs hold stable until rsp_valid&&rsp_ready. Then rsp_valid<=0, next state IDLE, result fields cleared to 0. No new command is accepted in the same cycle.
- Idle timer: counts consecutive IDLE cycles with cmd_valid=0; cleared on any other cycle.
  - On reaching IDLE_TIMEOUT: CS<=0, sleeping<=1, state SLEEP.
  - MAC_en, addr, word, query are retained.
  - cmd_valid on the timeout cycle wins: command accepted, no sleep.
- Mode is sticky across commands and sleep, so back-to-back searches switch mode only once.
- Reset asserted mid-operation: immediately forces reset values; any pending response is discarded.

Decomposition:
- Package bank_ctrl_pkg:
  - op encoding constants (OP_WRITE/OP_READ_Q/OP_READ_QB/OP_SEARCH),
  - state enum,
  - timer width derived from max(parameters, IDLE_TIMEOUT).
- One natural sub-module: bank_prio_enc (4-bit match vector -> hit flag + 2-bit lowest index), combinational, reused by later multi-bank blocks.

Test Plan:
- Reset then WRITE addr=0 data=AA: CS rises, WAKE for 1 cycle; w_en high exactly 1 cycle with addr=0, word=AA, MAC_en=1; one response with rsp_data=0.
- READ_Q addr=1 with bank_rdata=55: read_bar=0 for 2 cycles; rsp_data=55 two edges after accept. READ_QB then drives read_bar=1.
- SEARCH query=A with bank_match=0110 after MAC reads: MAC_en falls; SETTLE_CYCLES later query held 2 cycles; rsp_hit=1, rsp_hit_idx=1. Next SEARCH query=F with match=0000: no MODE cycle, rsp_hit=0.
- Response backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, later command waits. WRITE after SEARCH reinserts MODE with MAC_en=1.
- Idle 16 cycles -> CS=0, sleeping=1. cmd_valid exactly on cycle 16 -> no sleep. Command from SLEEP -> adds one WAKE cycle.
- Assert rst during OP of a 2-cycle read -> all outputs at reset values, no rsp_valid afterwards.
